// File: rtl/t03_alu_seq.sv
// rtl/t03_alu_seq.sv - sequential RV32IM execute unit: single-cycle base ops, iterative mul/div/rem
// Base ops retire in one cycle from IDLE; M ops run WIDTH shift-add / restoring-divide steps then a sign-fix cycle.
module t03_alu_seq #(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic             kill,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [2:0]         mop_q, mop_d;
   logic               neg_q, neg_d, rsign_q, rsign_d, divz_q, divz_d, dovf_q, dovf_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d, negative_q, negative_d, overflow_q, overflow_d;
   logic               done_q, done_d;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   logic [WIDTH:0]   add_w, sub_w;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] base_res;
   logic             base_ovf;

   assign add_w = {1'b0, src_a} + {1'b0, src_b};
   assign sub_w = {1'b0, src_a} - {1'b0, src_b};
   assign shamt = src_b[SHW-1:0];

   always_comb begin
      base_res = '0;
      base_ovf = 1'b0;
      case (op[3:0])
         4'b0000: begin base_res = add_w[WIDTH-1:0]; base_ovf = add_w[WIDTH]; end
         4'b1000: begin base_res = sub_w[WIDTH-1:0]; base_ovf = sub_w[WIDTH]; end
         4'b0100: base_res = src_a ^ src_b;
         4'b0110: base_res = src_a | src_b;
         4'b0111: base_res = src_a & src_b;
         4'b0001: base_res = src_a << shamt;
         4'b0101: base_res = src_a >> shamt;
         4'b1101: base_res = $unsigned($signed(src_a) >>> shamt);
         4'b0010: base_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         4'b0011: base_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
         default: base_res = '0;
      endcase
   end

   // Signed operand positions are latched as magnitudes; the sign fix happens in S_FIX.
   logic             sa, sb, smag_a, smag_b, sdiv;
   logic [WIDTH-1:0] a_in, b_in;

   assign sa     = src_a[WIDTH-1];
   assign sb     = src_b[WIDTH-1];
   assign sdiv   = op[2] & ~op[0];
   assign smag_a = (op[2:0] == 3'b001) | (op[2:0] == 3'b010) | sdiv;
   assign smag_b = (op[2:0] == 3'b001) | sdiv;
   assign a_in   = smag_a ? mag(src_a) : src_a;
   assign b_in   = smag_b ? mag(src_b) : src_b;

   logic [WIDTH:0]   mul_sum, div_sh;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign div_sh   = {rem_q, acc_q[WIDTH-1]};
   assign div_ge   = div_sh >= {1'b0, opnd_q};
   assign div_diff = div_sh[WIDTH-1:0] - opnd_q;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, remv, fix_res;

   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = divz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      remv = rsign_q ? -rem_q : rem_q;
      if (mop_q[2])
         fix_res = mop_q[1] ? remv : quo;
      else
         fix_res = (mop_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      rem_d      = rem_q;
      mop_d      = mop_q;
      neg_d      = neg_q;
      rsign_d    = rsign_q;
      divz_d     = divz_q;
      dovf_d     = dovf_q;
      result_d   = result_q;
      zero_d     = zero_q;
      negative_d = negative_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !kill) begin
               if (!op[4]) begin
                  result_d   = base_res;
                  zero_d     = (base_res == '0);
                  negative_d = base_res[WIDTH-1];
                  overflow_d = base_ovf;
                  done_d     = 1'b1;
               end else begin
                  mop_d   = op[2:0];
                  cnt_d   = '0;
                  rem_d   = '0;
                  case (op[2:0])
                     3'b001, 3'b100: neg_d = sa ^ sb;
                     3'b010:         neg_d = sa;
                     default:        neg_d = 1'b0;
                  endcase
                  rsign_d = (op[2:0] == 3'b110) & sa;
                  divz_d  = (src_b == '0);
                  dovf_d  = sdiv & (src_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&src_b);
                  if (op[2]) begin
                     acc_d   = {{WIDTH{1'b0}}, a_in};
                     opnd_d  = b_in;
                     state_d = S_DIV;
                  end else begin
                     acc_d   = {{WIDTH{1'b0}}, b_in};
                     opnd_d  = a_in;
                     state_d = S_MUL;
                  end
               end
            end
         end
         S_MUL: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = S_FIX;
         end
         S_DIV: begin
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
            rem_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = S_FIX;
         end
         default: begin
            result_d   = fix_res;
            zero_d     = (fix_res == '0);
            negative_d = fix_res[WIDTH-1];
            overflow_d = dovf_q;
            done_d     = 1'b1;
            state_d    = S_IDLE;
         end
      endcase
      // An abort drops the op silently and leaves the visible result untouched.
      if (kill && state_q != S_IDLE) begin
         state_d    = S_IDLE;
         done_d     = 1'b0;
         result_d   = result_q;
         zero_d     = zero_q;
         negative_d = negative_q;
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         rem_q      <= '0;
         mop_q      <= '0;
         neg_q      <= 1'b0;
         rsign_q    <= 1'b0;
         divz_q     <= 1'b0;
         dovf_q     <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b1;
         negative_q <= 1'b0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         rem_q      <= rem_d;
         mop_q      <= mop_d;
         neg_q      <= neg_d;
         rsign_q    <= rsign_d;
         divz_q     <= divz_d;
         dovf_q     <= dovf_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         negative_q <= negative_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign negative = negative_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_t03_alu_seq.sv
// tb/tb_t03_alu_seq.sv - randomized self-checking bench for t03_alu_seq against an arithmetic reference model
module tb_t03_alu_seq;

   localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b01000, OP_SRA = 5'b01101,
                          OP_SLT = 5'b00010, OP_SLTU = 5'b00011, OP_BAD = 5'b01111;
   localparam logic [4:0] OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010,
                          OP_MULHU = 5'b10011, OP_DIV = 5'b10100, OP_DIVU = 5'b10101,
                          OP_REM = 5'b10110, OP_REMU = 5'b10111;

   typedef struct { logic [4:0] o; logic [31:0] a, b, r; logic v; } vec_t;
   typedef struct { logic [4:0] o; logic [7:0] a, b, r; logic v; } vec8_t;

   logic        clk = 1'b0;
   logic        nrst, start, kill;
   logic [4:0]  op;
   logic [31:0] src_a, src_b, result;
   logic        busy, done, zero, negative, overflow;

   logic        start8, kill8, busy8, done8, zero8, neg8, ovf8;
   logic [4:0]  op8;
   logic [7:0]  a8, b8, result8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   t03_alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .nrst(nrst), .start(start), .op(op), .kill(kill),
      .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result),
      .zero(zero), .negative(negative), .overflow(overflow)
   );

   t03_alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .nrst(nrst), .start(start8), .op(op8), .kill(kill8),
      .src_a(a8), .src_b(b8), .busy(busy8), .done(done8), .result(result8),
      .zero(zero8), .negative(neg8), .overflow(ovf8)
   );

   function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic v);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      v  = 1'b0;
      r  = 32'd0;
      if (o[4]) begin
         case (o[2:0])
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: if (b == 32'd0) r = 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; v = 1'b1; end
                  else begin p = sa / sb; r = p[31:0]; end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 32'd0) r = a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 32'd0; v = 1'b1; end
                  else begin p = sa % sb; r = p[31:0]; end
            default: r = (b == 32'd0) ? a : a % b;
         endcase
      end else begin
         case (o[3:0])
            4'b0000: begin p = ua + ub; r = p[31:0]; v = p[32]; end
            4'b1000: begin r = a - b; v = (a < b); end
            4'b0100: r = a ^ b;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b0001: r = a << b[4:0];
            4'b0101: r = a >> b[4:0];
            4'b1101: begin p = sa >>> b[4:0]; r = p[31:0]; end
            4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
         endcase
      end
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(1, 15));
         4:       return 32'd0 - 32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   // Drives one request in the current cycle and returns once done rises; operands are scrambled after the start edge.
   task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
      op = o; src_a = a; src_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = 5'($urandom); src_a = $urandom; src_b = $urandom;
      lat = 1;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (done !== 1'b1) begin
         total++; bad++;
         $display("FAIL timeout op=%b waited=%0d required done", o, lat);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, done, result, zero, negative, overflow} !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset32 got busy=%b done=%b r=%h z=%b n=%b v=%b required 0 0 0 1 0 0",
                  busy, done, result, zero, negative, overflow);
      end
      total++;
      if ({busy8, done8, result8, zero8, neg8, ovf8} !== {1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset8 got busy=%b done=%b r=%h z=%b required 0 0 0 1", busy8, done8, result8, zero8);
      end
      nrst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_base();
      vec_t dv[6] = '{
         '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1},
         '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1},
         '{OP_SRA,  32'h8000_0000, 32'd35,        32'hF000_0000, 1'b0},
         '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
         '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
         '{OP_BAD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0}};
      logic [4:0] o; logic [31:0] a, b, er; logic ev; int lat;
      for (int i = 0; i < 306; i++) begin
         if (i < 6) begin o = dv[i].o; a = dv[i].a; b = dv[i].b; er = dv[i].r; ev = dv[i].v; end
         else begin o = {1'b0, 4'($urandom)}; a = rnd_val(); b = rnd_val(); model(o, a, b, er, ev); end
         run_op(o, a, b, lat);
         total++;
         if ({result, zero, negative, overflow} !== {er, er == 32'd0, er[31], ev} || lat != 1) begin
            bad++;
            $display("FAIL base op=%b a=%h b=%h got r=%h z=%b n=%b v=%b lat=%0d required r=%h v=%b lat=1",
                     o, a, b, result, zero, negative, overflow, lat, er, ev);
         end
      end
   endtask

   task automatic test_mul();
      vec_t dv[4] = '{
         '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0},
         '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
         '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
         '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0}};
      logic [4:0] o; logic [31:0] a, b, er; logic ev; int lat;
      for (int i = 0; i < 64; i++) begin
         if (i < 4) begin o = dv[i].o; a = dv[i].a; b = dv[i].b; er = dv[i].r; ev = dv[i].v; end
         else begin o = {3'b100, 2'($urandom)}; a = rnd_val(); b = rnd_val(); model(o, a, b, er, ev); end
         run_op(o, a, b, lat);
         total++;
         if ({result, zero, negative, overflow} !== {er, er == 32'd0, er[31], ev} || lat != 34) begin
            bad++;
            $display("FAIL mul op=%b a=%h b=%h got r=%h z=%b n=%b v=%b lat=%0d required r=%h v=%b lat=34",
                     o, a, b, result, zero, negative, overflow, lat, er, ev);
         end
      end
   endtask

   task automatic test_div();
      vec_t dv[8] = '{
         '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0},
         '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
         '{OP_DIVU, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0},
         '{OP_REMU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0},
         '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
         '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
         '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0},
         '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b0}};
      logic [4:0] o; logic [31:0] a, b, er; logic ev; int lat;
      for (int i = 0; i < 88; i++) begin
         if (i < 8) begin o = dv[i].o; a = dv[i].a; b = dv[i].b; er = dv[i].r; ev = dv[i].v; end
         else begin o = {3'b101, 2'($urandom)}; a = rnd_val(); b = rnd_val(); model(o, a, b, er, ev); end
         run_op(o, a, b, lat);
         total++;
         if ({result, zero, negative, overflow} !== {er, er == 32'd0, er[31], ev} || lat != 34) begin
            bad++;
            $display("FAIL div op=%b a=%h b=%h got r=%h z=%b n=%b v=%b lat=%0d required r=%h v=%b lat=34",
                     o, a, b, result, zero, negative, overflow, lat, er, ev);
         end
      end
   endtask

   task automatic test_handshake();
      logic [4:0] o; logic [31:0] a, b, er; logic ev; int lat, extra;
      op = OP_DIV; src_a = 32'hFFFF_FFF9; src_b = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 200) begin
         start = (lat == 3); op = OP_ADD; src_a = 32'd1; src_b = 32'd1;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      total++;
      if (result !== 32'hFFFF_FFFD || lat != 34) begin
         bad++;
         $display("FAIL start_while_busy got r=%h lat=%0d required r=fffffffd lat=34", result, lat);
      end
      extra = 0;
      repeat (4) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
      total++;
      if (extra != 0) begin
         bad++;
         $display("FAIL no_queue got extra_done=%0d required 0", extra);
      end

      run_op(OP_MUL, 32'd3, 32'd5, lat);
      total++;
      if (result !== 32'd15 || lat != 34) begin
         bad++;
         $display("FAIL b2b_mul got r=%h lat=%0d required r=0000000f lat=34", result, lat);
      end
      run_op(OP_SUB, 32'd10, 32'd4, lat);
      total++;
      if (result !== 32'd6 || lat != 1) begin
         bad++;
         $display("FAIL start_in_done got r=%h lat=%0d required r=00000006 lat=1", result, lat);
      end
      for (int i = 0; i < 8; i++) begin
         o = {1'b0, 4'($urandom)}; a = rnd_val(); b = rnd_val(); model(o, a, b, er, ev);
         run_op(o, a, b, lat);
         total++;
         if ({result, overflow} !== {er, ev} || lat != 1) begin
            bad++;
            $display("FAIL b2b_base op=%b got r=%h v=%b lat=%0d required r=%h v=%b lat=1",
                     o, result, overflow, lat, er, ev);
         end
      end
      run_op(OP_DIVU, 32'd100, 32'd7, lat);
      total++;
      if (result !== 32'd14 || lat != 34) begin
         bad++;
         $display("FAIL b2b_divu got r=%h lat=%0d required r=0000000e lat=34", result, lat);
      end

      op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL kill_idle got busy=%b required 0", busy);
      end
      extra = 0;
      repeat (40) begin if (done === 1'b1) extra++; @(posedge clk); #1; end
      total++;
      if (extra != 0 || {result, zero, negative, overflow} !== {32'd14, 3'b000}) begin
         bad++;
         $display("FAIL kill_hold got done_count=%0d r=%h z=%b n=%b v=%b required 0 0000000e 0 0 0",
                  extra, result, zero, negative, overflow);
      end
   endtask

   task automatic test_reset_mid_mul();
      int lat;
      run_op(OP_ADD, 32'd2, 32'd2, lat);
      op = OP_MUL; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_mul_busy got busy=%b required 1", busy);
      end
      nrst = 1'b0;
      #1;
      total++;
      if ({busy, done, result, zero} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
         bad++;
         $display("FAIL async_reset got busy=%b done=%b r=%h z=%b required 0 0 00000000 1", busy, done, result, zero);
      end
      @(posedge clk); #1;
      nrst = 1'b1;
      @(posedge clk); #1;
      run_op(OP_ADD, 32'd2, 32'd3, lat);
      total++;
      if ({result, zero, overflow} !== {32'd5, 1'b0, 1'b0} || lat != 1) begin
         bad++;
         $display("FAIL after_reset_add got r=%h z=%b v=%b lat=%0d required r=00000005 z=0 v=0 lat=1",
                  result, zero, overflow, lat);
      end
   endtask

   task automatic test_width8();
      vec8_t dv[6] = '{
         '{OP_MULHU, 8'h80, 8'h80, 8'h40, 1'b0},
         '{OP_MUL,   8'h0F, 8'h0F, 8'hE1, 1'b0},
         '{OP_DIV,   8'hF9, 8'h02, 8'hFD, 1'b0},
         '{OP_REM,   8'hF9, 8'h02, 8'hFF, 1'b0},
         '{OP_DIV,   8'h80, 8'hFF, 8'h80, 1'b1},
         '{OP_DIVU,  8'h07, 8'h00, 8'hFF, 1'b0}};
      int lat;
      for (int i = 0; i < 6; i++) begin
         op8 = dv[i].o; a8 = dv[i].a; b8 = dv[i].b; start8 = 1'b1;
         @(posedge clk); #1;
         start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
         lat = 1;
         while (done8 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
         total++;
         if ({result8, zero8, neg8, ovf8} !== {dv[i].r, dv[i].r == 8'd0, dv[i].r[7], dv[i].v} || lat != 10) begin
            bad++;
            $display("FAIL w8 op=%b a=%h b=%h got r=%h v=%b lat=%0d required r=%h v=%b lat=10",
                     dv[i].o, dv[i].a, dv[i].b, result8, ovf8, lat, dv[i].r, dv[i].v);
         end
      end
   endtask

   initial begin
      nrst = 1'b0; start = 1'b0; kill = 1'b0; op = 5'd0; src_a = 32'd0; src_b = 32'd0;
      start8 = 1'b0; kill8 = 1'b0; op8 = 5'd0; a8 = 8'd0; b8 = 8'd0;
      test_reset();
      test_base();
      test_mul();
      test_div();
      test_handshake();
      test_reset_mid_mul();
      test_width8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/t03_alu_seq.md
# t03_alu_seq

Parametrised, sequential RV32IM execute unit for the team_03 core. It carries the existing single-cycle integer operation set, widened to a WIDTH parameter and registered behind a start/done handshake. It adds iterative multiply, divide and remainder (RV M-extension) engines. It sits in the execute stage; the control unit holds the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, datapath width. Must be a power of 2 and ≥ 8. `SHW = $clog2(WIDTH)` is the shift-amount width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `nrst`  in  1  reset. Asynchronous and active-low.
- `start`  in  1  request. Sampled only in IDLE.
- `op`  in  5  operation code.
  - `op[4]=0`, base ops: ADD 0000, SUB 1000, XOR 0100, OR 0110, AND 0111, SLL 0001, SRL 0101, SRA 1101, SLT 0010, SLTU 0011.
  - `op[4]=1`, M ops: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
  - Unlisted base codes produce result 0.
- `kill`  in  1  abort the in-flight op.
- `src_a`, `src_b`  in  WIDTH  operands. Already muxed by the caller (pc/imm/zero selection is external).
- `busy`  out  1  high when not IDLE.
- `done`  out  1  one-cycle pulse: result valid.
- `result`  out  WIDTH  registered. Held until the next `done`.
- `zero`, `negative`, `overflow`  out  1  registered flags. They update with `result`.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, `start=1`, base op: compute combinationally and register `result` and flags at that edge. `done=1` next cycle. State stays IDLE.
- IDLE, `start=1`, M op: latch operands at that edge.
  - Latch magnitudes for signed operand positions: MULH both; MULHSU `src_a` only; DIV/REM both.
  - Latch sign-fix bits.
  - Clear the iteration counter; go to MUL or DIV.
- MUL: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator. After WIDTH iterations go to FIX.
- DIV: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder. After WIDTH iterations go to FIX.
- FIX: apply sign correction.
  - Product: negate if operand signs differ.
  - Quotient: negate if signs differ.
  - Remainder: takes the dividend's sign.
  - Select low half (MUL) or high half (MULH*), or quotient/remainder.
  - Register `result` and flags. Pulse `done`. Return to IDLE.
- Base arithmetic:
  - ADD: `overflow` = unsigned carry-out.
  - SUB: `overflow` = unsigned borrow.
  - Shifts use `src_b[SHW-1:0]` only.
  - SRA is arithmetic.
  - SLT is signed compare; SLTU is unsigned. Both give result 0 or 1.
- Flags:
  - `zero` = (result == 0).
  - `negative` = result[WIDTH-1].
  - `overflow` = 0 for all logic/shift/compare ops and all MUL ops.
- Divide by zero: DIV/DIVU give all-ones. REM/REMU give the dividend. `overflow=0`.
- Signed overflow (DIV/REM with `src_a` = most-negative, `src_b` = −1): DIV gives most-negative, REM gives 0, `overflow=1`.
- `start` while busy: ignored. No queueing.
- `kill` while busy: return to IDLE next edge. No `done`. `result` and flags keep their previous values. `kill` in IDLE has no effect; `kill` beats a same-cycle `start`.

## Timing
- Reset (`nrst=0`, asynchronous, any state including mid-iteration):
  - State → IDLE; counter, accumulators and `result` → 0.
  - `done=0`, `busy=0`, `zero=1`, `negative=0`, `overflow=0`.
- Base op latency: `done` high in the cycle after the `start` edge (1 cycle).
- M op latency: `start` edge E0; iterations on E1…E_WIDTH; FIX at E_(WIDTH+1); `done` high in the following cycle.
  - Total: WIDTH+2 cycles from E0 to `done`.
  - `busy` is high for WIDTH+1 cycles and falls as `done` rises.
- Latency is fixed and independent of operand values. There is no early termination.
- `done` always coincides with state = IDLE. A `start` in the same cycle as `done` is accepted. Back-to-back base ops give `done` every cycle.
- Operands need only be valid in the `start` cycle.

## Test plan
- Reset mid-MUL (assert `nrst` low at iteration 10, WIDTH=32): immediately `busy=0`, `done=0`, `result=0`, `zero=1`. A new ADD 2+3 afterwards gives 5 one cycle later.
- Base sweep, WIDTH=32:
  - ADD 0xFFFFFFFF+1 → 0, `zero=1`, `overflow=1`.
  - SUB 0−1 → 0xFFFFFFFF, `negative=1`, `overflow=1`.
  - SRA 0x80000000 by 35 → 0xF0000000 (shift amount 3).
  - SLT −1 vs 1 → 1. SLTU −1 vs 1 → 0.
- Multiply, WIDTH=32:
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 1.
  - MULHU same operands → 0xFFFFFFFE.
  - MULH same operands → 0.
  - MULHSU −1×2 → 0xFFFFFFFF.
  - `done` exactly 34 cycles after `start`.
- Divide:
  - DIV −7/2 → −3; REM → −1.
  - DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
  - DIV 0x80000000/−1 → 0x80000000, `overflow=1`; REM same operands → 0.
- Handshake:
  - `start` pulsed during DIV is ignored; `result` reflects only the first op.
  - `start` in the `done` cycle launches the next op.
  - `kill` at iteration 5 returns to IDLE with no `done` and `result` unchanged.
- Parametrisation: at WIDTH=8, MUL 0x80×0x80 via MULHU → 0x40, with `done` 10 cycles after `start`.
